// File: rtl/ula_controle.sv
// Multi-cycle sequencer driving the shared ula from a private 4-entry register bank.
// Optional build macro ULA_CTRL_FAST_EN drops the EXEC state for a single-cycle ula.
module ula_controle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [2:0]       ULAControl,
  output logic [WIDTH-1:0] scrA,
  output logic [WIDTH-1:0] scrB,
  input  logic [WIDTH-1:0] ULAResult,
  input  logic             Z,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             z_out,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       rd;
  logic             instr_unused;

  assign instr_unused = ^instr[5:0];
  assign instr_ready  = (state == IDLE);
  assign dbg_data     = regs[dbg_addr];

  // result_out doubles as the captured-result register; the bank is written
  // from it on the WRITE edge, so writeback is visible the cycle after WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ULAControl <= '0;
      scrA       <= '0;
      scrB       <= '0;
      result_out <= '0;
      z_out      <= 1'b0;
      done       <= 1'b0;
      rd         <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            rd <= instr[11:10];
            if (instr[15]) begin
              result_out <= WIDTH'(instr[7:0]);
              z_out      <= (instr[7:0] == 8'd0);
              done       <= 1'b1;
              state      <= WRITE;
            end else begin
              ULAControl <= instr[14:12];
              scrA       <= regs[instr[9:8]];
              scrB       <= regs[instr[7:6]];
              state      <= READ;
            end
          end
        end
        READ: begin
`ifdef ULA_CTRL_FAST_EN
          result_out <= ULAResult;
          z_out      <= Z;
          done       <= 1'b1;
          state      <= WRITE;
`else
          state      <= EXEC;
`endif
        end
        EXEC: begin
          result_out <= ULAResult;
          z_out      <= Z;
          done       <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          regs[rd] <= result_out;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_controle.sv
// Self-checking bench for ula_controle: a behavioural ula plus a register-bank
// model predict results, latency and operand values for random instructions.
module tb_ula_controle;

`ifdef ULA_CTRL_FAST_EN
  localparam int ALU_LAT = 2;
`else
  localparam int ALU_LAT = 3;
`endif

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  ULAControl;
  logic [7:0]  scrA;
  logic [7:0]  scrB;
  logic [7:0]  ULAResult;
  logic        Z;
  logic        done;
  logic [7:0]  result_out;
  logic        z_out;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] mRegs [4];
  logic [2:0] mCtrl;
  logic [7:0] mA;
  logic [7:0] mB;

  ula_controle #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ULAControl(ULAControl), .scrA(scrA), .scrB(scrB),
    .ULAResult(ULAResult), .Z(Z), .done(done), .result_out(result_out),
    .z_out(z_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbitrary operation table standing in for the real ula
  function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return (a < b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  assign ULAResult = aluRef(ULAControl, scrA, scrB);
  assign Z         = (ULAResult == 8'd0);

  function automatic logic [15:0] mkAlu(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    logic [5:0] junk;
    junk = 6'($urandom);
    return {1'b0, op, rd, rs1, rs2, junk};
  endfunction

  function automatic logic [15:0] mkLi(input logic [1:0] rd, input logic [7:0] imm);
    logic [2:0] junkA;
    logic [1:0] junkB;
    junkA = 3'($urandom);
    junkB = 2'($urandom);
    return {1'b1, junkA, rd, junkB, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction on the model state
  task automatic modelStep(input logic [15:0] w, output logic [7:0] res);
    if (w[15]) begin
      res = w[7:0];
    end else begin
      mCtrl = w[14:12];
      mA    = mRegs[w[9:8]];
      mB    = mRegs[w[7:6]];
      res   = aluRef(mCtrl, mA, mB);
    end
    mRegs[w[11:10]] = res;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 8'd0;
    mCtrl = 3'd0;
    mA    = 8'd0;
    mB    = 8'd0;
  endtask

  task automatic checkRegs(input string tag);
    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      checkOutput($sformatf("%s_r%0d", tag, a), dbg_data, mRegs[a]);
    end
  endtask

  // Issue one instruction (called just after a falling edge, DUT idle)
  task automatic applyStimulus(input logic [15:0] w);
    logic       isLi;
    logic [1:0] rd;
    logic [7:0] oldRd;
    logic [7:0] expRes;
    int         expLat;
    int         cyc;
    isLi   = w[15];
    rd     = w[11:10];
    oldRd  = mRegs[rd];
    modelStep(w, expRes);
    expLat = isLi ? 1 : ALU_LAT;
    instr       = w;
    instr_valid = 1'b1;
    dbg_addr    = rd;
    checkOutput("ready_idle", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (done) break;
      checkOutput("ready_busy", instr_ready, 0);
      if (!isLi) begin
        checkOutput("ula_ctrl", ULAControl, mCtrl);
        checkOutput("ula_a", scrA, mA);
        checkOutput("ula_b", scrB, mB);
      end
      @(posedge clk);
    end
    checkOutput("done_latency", cyc, expLat);
    checkOutput("result_out", result_out, expRes);
    checkOutput("z_out", z_out, expRes == 8'd0);
    checkOutput("hold_ctrl", ULAControl, mCtrl);
    checkOutput("hold_a", scrA, mA);
    checkOutput("hold_b", scrB, mB);
    checkOutput("dbg_before_wb", dbg_data, oldRd);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_single", done, 0);
    checkOutput("dbg_after_wb", dbg_data, expRes);
    checkOutput("ready_back", instr_ready, 1);
    checkOutput("result_hold", result_out, expRes);
  endtask

  function automatic logic [15:0] randInstr();
    if ($urandom_range(0, 2) == 0)
      return mkLi(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    return mkAlu(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
  endfunction

  // Source holds instr_valid high; three instructions must complete in order
  task automatic queueTest();
    logic [15:0] q [3];
    logic [7:0]  exp [3];
    int          idx;
    int          nDone;
    logic        acc;
    logic        prevAcc;
    for (int i = 0; i < 3; i++) begin
      q[i] = (i == 0) ? mkLi(2'($urandom), 8'($urandom)) : randInstr();
      modelStep(q[i], exp[i]);
    end
    idx = 0;
    nDone = 0;
    prevAcc = 1'b0;
    instr = q[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (done) begin
        if (nDone < 3) checkOutput($sformatf("queue_res%0d", nDone), result_out, exp[nDone]);
        nDone++;
      end
      if (prevAcc) checkOutput("queue_busy", instr_ready, 0);
      acc = instr_valid && instr_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) instr = q[idx];
        else instr_valid = 1'b0;
      end
      prevAcc = acc;
      @(negedge clk);
    end
    checkOutput("queue_done_count", nDone, 3);
    checkOutput("queue_accepts", idx, 3);
    checkRegs("queue");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, instr_ready, 1);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_ctrl"}, ULAControl, 0);
    checkOutput({tag, "_a"}, scrA, 0);
    checkOutput({tag, "_b"}, scrB, 0);
    checkOutput({tag, "_result"}, result_out, 0);
    checkOutput({tag, "_z"}, z_out, 0);
  endtask

  task automatic resetTest();
    applyStimulus(mkLi(2'd3, 8'd5));
    applyStimulus(mkLi(2'd1, 8'd7));
    instr       = mkAlu(3'd0, 2'd3, 2'd1, 2'd3);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
`ifndef ULA_CTRL_FAST_EN
    @(posedge clk);
    #1;
`endif
    reset = 1'b1;
    #2;
    modelReset();
    checkResetOutputs("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rst_no_done", done, 0);
    end
    checkResetOutputs("rst_after");
    checkRegs("rst");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'd0;
    dbg_addr    = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");
    checkRegs("reset");

    applyStimulus(mkLi(2'd1, 8'd3));
    applyStimulus(mkLi(2'd2, 8'd2));
    applyStimulus(mkAlu(3'd0, 2'd3, 2'd1, 2'd2));
    checkOutput("plan_r3", mRegs[3], 8'd5);
    applyStimulus(mkAlu(3'd1, 2'd1, 2'd2, 2'd2));
    applyStimulus(mkLi(2'd0, 8'd0));
    checkRegs("directed");

    for (int n = 0; n < 40; n++) applyStimulus(randInstr());
    checkRegs("random");

    queueTest();
    queueTest();

    resetTest();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
